// File: rtl/game_pkg.sv
// Constants and types shared by the character motion path and the VGA renderer.
// The renderer unpacks char_data with the same field order that pack_char uses.
package game_pkg;

  localparam int COORD_W    = 16;
  localparam int CHAR_BUS_W = 64;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int SCREEN_FLOOR_Y = 460;
  localparam int SCREEN_CEIL_Y  = 80;

  typedef enum logic {
    GROUND = 1'b0,
    AIR    = 1'b1
  } motion_state_t;

  // Bus order, MSB first: {x_leng, y_leng, x, y}
  function automatic logic [CHAR_BUS_W-1:0] pack_char(
    input logic [COORD_W-1:0] x_leng,
    input logic [COORD_W-1:0] y_leng,
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y
  );
    return {x_leng, y_leng, x, y};
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an active-low button, with a one-tick pulse when
// the synchronized level falls (button pressed).
module btn_sync (
  input  logic clk,
  input  logic srst,
  input  logic btn,
  output logic level,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic hist_reg;

  // Released (high) after reset so a button already held is not seen as a press.
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      hist_reg <= 1'b1;
    end else begin
      meta_reg <= btn;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign fall  = hist_reg & ~sync_reg;

endmodule

// File: rtl/char_motion_ctrl.sv
// Player-character motion: synchronized buttons drive horizontal stepping with
// edge clamps and a GROUND/AIR jump with constant gravity and a ceiling.
module char_motion_ctrl
  import game_pkg::*;
#(
  parameter int X_INIT  = 100,
  parameter int CHAR_W  = 40,
  parameter int CHAR_H  = 40,
  parameter int FLOOR_Y = SCREEN_FLOOR_Y,
  parameter int CEIL_Y  = SCREEN_CEIL_Y,
  parameter int STEP    = 20,
  parameter int X_MIN   = 20,
  parameter int X_MAX   = 550,
  parameter int JUMP_V0 = 24,
  parameter int GRAVITY = 2,
  parameter int V_MAX   = 24
) (
  input  logic                  action_clk,
  input  logic                  iRST,
  input  logic                  move_right,
  input  logic                  move_left,
  input  logic                  move_jump,
  output logic [CHAR_BUS_W-1:0] char_data,
  output logic                  on_ground,
  output logic                  landed
);

  localparam int SW = COORD_W + 1;

  localparam logic [COORD_W-1:0] X_INIT_C = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] X_MIN_C  = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] W_C      = COORD_W'(CHAR_W);
  localparam logic [COORD_W-1:0] H_C      = COORD_W'(CHAR_H);
  localparam logic [COORD_W-1:0] GROUND_Y = COORD_W'(FLOOR_Y - CHAR_H);
  localparam logic [COORD_W-1:0] CEIL_Y_C = COORD_W'(CEIL_Y);

  localparam logic signed [COORD_W-1:0] VY_JUMP = COORD_W'(-JUMP_V0);
  localparam logic signed [COORD_W-1:0] V_MAX_C = COORD_W'(V_MAX);
  localparam logic signed [SW-1:0] GROUND_Y_S = SW'(FLOOR_Y - CHAR_H);
  localparam logic signed [SW-1:0] CEIL_Y_S   = SW'(CEIL_Y);
  localparam logic signed [SW-1:0] V_MAX_S    = SW'(V_MAX);
  localparam logic signed [SW-1:0] GRAV_S     = SW'(GRAVITY);

  // Button order: 0 = right, 1 = left, 2 = jump (all active-low).
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic       jump_fall;
  logic [1:0] edge_unused;

  assign btn_raw = {move_jump, move_left, move_right};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      if (gi == 2) begin : g_jump
        btn_sync u_sync (
          .clk   (action_clk),
          .srst  (iRST),
          .btn   (btn_raw[gi]),
          .level (btn_level[gi]),
          .fall  (jump_fall)
        );
      end else begin : g_move
        btn_sync u_sync (
          .clk   (action_clk),
          .srst  (iRST),
          .btn   (btn_raw[gi]),
          .level (btn_level[gi]),
          .fall  (edge_unused[gi])
        );
      end
    end
  endgenerate

  motion_state_t             state_reg, state_next;
  logic [COORD_W-1:0]        x_reg, x_next;
  logic [COORD_W-1:0]        y_reg, y_next;
  logic signed [COORD_W-1:0] vy_reg, vy_next;
  logic                      landed_reg, landed_next;

  logic                 go_right;
  logic                 go_left;
  logic signed [SW-1:0] y_sum;
  logic signed [SW-1:0] vy_grav;

  assign go_right = ~btn_level[0] & btn_level[1];
  assign go_left  = ~btn_level[1] & btn_level[0];
  assign y_sum    = $signed({1'b0, y_reg}) + $signed({vy_reg[COORD_W-1], vy_reg});
  assign vy_grav  = $signed({vy_reg[COORD_W-1], vy_reg}) + GRAV_S;

  always_ff @(posedge action_clk) begin
    if (iRST) begin
      state_reg  <= GROUND;
      x_reg      <= X_INIT_C;
      y_reg      <= GROUND_Y;
      vy_reg     <= '0;
      landed_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      vy_reg     <= vy_next;
      landed_reg <= landed_next;
    end
  end

  // Clamp tests are done before the add/subtract so x never wraps.
  always_comb begin
    x_next = x_reg;
    if (go_right) begin
      x_next = (x_reg >= X_MAX_C - STEP_C) ? X_MAX_C : x_reg + STEP_C;
    end else if (go_left) begin
      x_next = (x_reg <= X_MIN_C + STEP_C) ? X_MIN_C : x_reg - STEP_C;
    end
  end

  always_comb begin
    state_next  = state_reg;
    y_next      = y_reg;
    vy_next     = vy_reg;
    landed_next = 1'b0;
    unique case (state_reg)
      GROUND: begin
        y_next  = GROUND_Y;
        vy_next = '0;
        if (jump_fall) begin
          state_next = AIR;
          vy_next    = VY_JUMP;
        end
      end
      AIR: begin
        if (y_sum >= GROUND_Y_S) begin
          state_next  = GROUND;
          y_next      = GROUND_Y;
          vy_next     = '0;
          landed_next = 1'b1;
        end else if (y_sum < CEIL_Y_S) begin
          y_next  = CEIL_Y_C;
          vy_next = '0;
        end else begin
          y_next  = y_sum[COORD_W-1:0];
          vy_next = (vy_grav > V_MAX_S) ? V_MAX_C : vy_grav[COORD_W-1:0];
        end
      end
    endcase
  end

  always_comb begin
    char_data = pack_char(W_C, H_C, x_reg, y_reg);
    on_ground = (state_reg == GROUND);
    landed    = landed_reg;
  end

endmodule
